// File: rtl/dsc_cache_ctrl.sv
// Descriptor cache controller: write pass-through, per-entry valid tracking and a
// round-robin read arbiter that tags the 2-cycle SRAM read pipeline with the requester id.
module dsc_cache_ctrl #(
    parameter int unsigned DATA_W = 88,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned NUM_RD = 2,
    localparam int unsigned DEPTH = 2 ** ADDR_W,
    localparam int unsigned ID_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
    input  logic                     CLK,
    input  logic                     ARST_N,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    input  logic [DEPTH-1:0]         inval,
    output logic [DEPTH-1:0]         entry_valid,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_gnt,
    output logic [NUM_RD-1:0]        rd_miss,
    output logic                     rd_vld,
    output logic [ID_W-1:0]          rd_id,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     sram_w_en,
    output logic [ADDR_W-1:0]        sram_w_addr,
    output logic [DATA_W-1:0]        sram_w_data,
    output logic [ADDR_W-1:0]        sram_r_addr,
    output logic                     sram_r_addr_en,
    output logic                     sram_r_data_en,
    input  logic [DATA_W-1:0]        sram_r_data,
    output logic                     sram_blk_en
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              s1_vld_q, s2_vld_q;
    logic [ID_W-1:0]   s1_id_q, s2_id_q;
    logic              blk_en_q;

    logic [NUM_RD-1:0] cand;
    logic [NUM_RD-1:0] gnt_oh;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_id;
    logic [ADDR_W-1:0] gnt_addr;
    logic              hit;

    always_comb begin
        int unsigned idx;
        int unsigned nxt;
        cand     = '0;
        gnt_any  = 1'b0;
        gnt_id   = '0;
        gnt_addr = '0;
        gnt_oh   = '0;
        idx      = 0;
        nxt      = 0;
        // A read that collides with this cycle's write address sits out and retries.
        for (int i = 0; i < NUM_RD; i++) begin
            cand[i] = rd_req[i] && !(wr_req && (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr));
        end
        for (int k = 0; k < NUM_RD; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_RD) idx = idx - NUM_RD;
            if (!gnt_any && cand[ID_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
        for (int i = 0; i < NUM_RD; i++) begin
            if (ID_W'(i) == gnt_id) gnt_addr = rd_addr[i*ADDR_W +: ADDR_W];
        end
        gnt_oh[gnt_id] = gnt_any;
        hit = valid_q[gnt_addr];

        nxt = int'(gnt_id) + 1;
        if (!gnt_any)          ptr_d = ptr_q;
        else if (nxt >= NUM_RD) ptr_d = '0;
        else                    ptr_d = ID_W'(nxt);

        // Write wins over a simultaneous invalidate of the same entry.
        valid_d = valid_q & ~inval;
        if (wr_req) valid_d[wr_addr] = 1'b1;
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            valid_q  <= '0;
            ptr_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_id_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_id_q  <= '0;
            blk_en_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            ptr_q    <= ptr_d;
            s1_vld_q <= gnt_any && hit;
            s1_id_q  <= gnt_id;
            s2_vld_q <= s1_vld_q;
            s2_id_q  <= s1_id_q;
            blk_en_q <= 1'b1;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    always_comb begin
        wr_ack         = wr_req & ARST_N;
        sram_w_en      = wr_req & ARST_N;
        sram_w_addr    = ARST_N ? wr_addr : '0;
        sram_w_data    = ARST_N ? wr_data : '0;
        rd_gnt         = gnt_oh & {NUM_RD{ARST_N}};
        rd_miss        = gnt_oh & {NUM_RD{ARST_N & ~hit}};
        sram_r_addr_en = gnt_any & hit & ARST_N;
        sram_r_addr    = sram_r_addr_en ? gnt_addr : '0;
    end

    assign entry_valid    = valid_q;
    assign sram_r_data_en = s1_vld_q;
    assign rd_vld         = s2_vld_q;
    assign rd_id          = s2_id_q;
    assign rd_data        = sram_r_data;
    assign sram_blk_en    = blk_en_q;

endmodule

// File: tb/tb_dsc_cache_ctrl.sv
// Directed bench for dsc_cache_ctrl with a behavioural SRAM (registered address and data).
module tb_dsc_cache_ctrl;

    localparam logic [87:0] DA5  = {11{8'hA5}};
    localparam logic [87:0] D0   = {11{8'h10}};
    localparam logic [87:0] D1   = {11{8'h21}};
    localparam logic [87:0] D3   = {11{8'h3C}};
    localparam logic [87:0] NEW1 = {11{8'h5A}};
    localparam logic [87:0] NEW3 = {11{8'hC3}};
    localparam logic [87:0] X1   = {11{8'h77}};

    logic        CLK = 1'b0;
    logic        ARST_N = 1'b0;
    logic        wr_req;
    logic [1:0]  wr_addr;
    logic [87:0] wr_data;
    logic        wr_ack;
    logic [3:0]  inval;
    logic [3:0]  entry_valid;
    logic [1:0]  rd_req;
    logic [3:0]  rd_addr;
    logic [1:0]  rd_gnt;
    logic [1:0]  rd_miss;
    logic        rd_vld;
    logic [0:0]  rd_id;
    logic [87:0] rd_data;
    logic        sram_w_en;
    logic [1:0]  sram_w_addr;
    logic [87:0] sram_w_data;
    logic [1:0]  sram_r_addr;
    logic        sram_r_addr_en;
    logic        sram_r_data_en;
    logic [87:0] sram_r_data;
    logic        sram_blk_en;

    int err_cnt = 0;
    int chk_cnt = 0;
    int vld_seen;

    always #5 CLK = ~CLK;

    dsc_cache_ctrl dut (
        .CLK            (CLK),
        .ARST_N         (ARST_N),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .inval          (inval),
        .entry_valid    (entry_valid),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_miss        (rd_miss),
        .rd_vld         (rd_vld),
        .rd_id          (rd_id),
        .rd_data        (rd_data),
        .sram_w_en      (sram_w_en),
        .sram_w_addr    (sram_w_addr),
        .sram_w_data    (sram_w_data),
        .sram_r_addr    (sram_r_addr),
        .sram_r_addr_en (sram_r_addr_en),
        .sram_r_data_en (sram_r_data_en),
        .sram_r_data    (sram_r_data),
        .sram_blk_en    (sram_blk_en)
    );

    // SRAM model: read-during-write returns the old word.
    logic [87:0] mem [4];
    logic [1:0]  m_raddr_q;
    always @(posedge CLK) if (sram_w_en) mem[sram_w_addr] <= sram_w_data;
    always @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            m_raddr_q   <= '0;
            sram_r_data <= '0;
        end else begin
            if (sram_r_addr_en) m_raddr_q <= sram_r_addr;
            if (sram_r_data_en) sram_r_data <= mem[m_raddr_q];
        end
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        inval   = '0;
        rd_req  = '0;
        rd_addr = '0;
    endtask

    task automatic write(input logic [1:0] a, input logic [87:0] d);
        @(negedge CLK);
        idle();
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        idle();
        // Inputs active during reset must not leak to outputs.
        wr_req = 1'b1;
        rd_req = 2'b11;
        @(negedge CLK); #1;
        check("rst_valid", entry_valid, 4'b0000);
        check("rst_wr_ack", wr_ack, 1'b0);
        check("rst_w_en", sram_w_en, 1'b0);
        check("rst_gnt", rd_gnt, 2'b00);
        check("rst_rd_vld", rd_vld, 1'b0);
        check("rst_blk_en", sram_blk_en, 1'b0);
        check("rst_rd_data", rd_data, 88'h0);
        idle();
        @(negedge CLK);
        ARST_N = 1'b1;
        @(negedge CLK); #1;
        check("blk_en", sram_blk_en, 1'b1);

        // Miss on invalid entry 0.
        @(negedge CLK);
        rd_req = 2'b01; rd_addr = 4'b0000; #1;
        check("miss_gnt", rd_gnt, 2'b01);
        check("miss_pulse", rd_miss, 2'b01);
        check("miss_raddr_en", sram_r_addr_en, 1'b0);
        @(negedge CLK); idle(); #1;
        check("miss_pulse_end", rd_miss, 2'b00);
        check("miss_rdata_en", sram_r_data_en, 1'b0);
        @(negedge CLK); #1;
        check("miss_no_vld", rd_vld, 1'b0);

        // Write entry 2, then read it back.
        write(2'd2, DA5); #1;
        check("wr_ack", wr_ack, 1'b1);
        check("w_en", sram_w_en, 1'b1);
        check("w_addr", sram_w_addr, 2'd2);
        check("w_data", sram_w_data, DA5);
        @(negedge CLK); idle();
        rd_req = 2'b01; rd_addr = 4'b0010; #1;
        check("valid_e2", entry_valid, 4'b0100);
        check("rd2_gnt", rd_gnt, 2'b01);
        check("rd2_raddr_en", sram_r_addr_en, 1'b1);
        check("rd2_raddr", sram_r_addr, 2'd2);
        @(negedge CLK); idle(); #1;
        check("rd2_rdata_en", sram_r_data_en, 1'b1);
        check("rd2_vld_early", rd_vld, 1'b0);
        @(negedge CLK); #1;
        check("rd2_vld", rd_vld, 1'b1);
        check("rd2_id", rd_id, 1'b0);
        check("rd2_data", rd_data, DA5);
        @(negedge CLK); #1;
        check("rd2_vld_end", rd_vld, 1'b0);

        write(2'd0, D0);
        write(2'd1, D1);
        write(2'd3, D3);
        @(negedge CLK); idle(); #1;
        check("valid_all", entry_valid, 4'b1111);

        // Both requesters held: pointer is at 1, so req1 (addr 3) wins first.
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            rd_req  = (k < 6) ? 2'b11 : 2'b00;
            rd_addr = {2'd3, 2'd0};
            #1;
            if (k < 6) check($sformatf("burst_gnt%0d", k), rd_gnt, ((k % 2) == 0) ? 2'b10 : 2'b01);
            if (k >= 2) begin
                check($sformatf("burst_vld%0d", k), rd_vld, 1'b1);
                check($sformatf("burst_id%0d", k), rd_id, ((k % 2) == 0) ? 1'b1 : 1'b0);
                check($sformatf("burst_data%0d", k), rd_data, ((k % 2) == 0) ? D3 : D0);
            end
        end

        // Single req1 grant moves the pointer back to 0.
        @(negedge CLK); idle();
        rd_req = 2'b10; rd_addr = {2'd3, 2'd0}; #1;
        check("ptr_gnt", rd_gnt, 2'b10);
        @(negedge CLK); idle();
        @(negedge CLK); #1;
        check("ptr_data", rd_data, D3);

        // Write to entry 1 masks req0 reading entry 1 despite pointer at 0.
        @(negedge CLK);
        wr_req = 1'b1; wr_addr = 2'd1; wr_data = NEW1;
        rd_req = 2'b11; rd_addr = {2'd3, 2'd1}; #1;
        check("coll_gnt", rd_gnt, 2'b10);
        @(negedge CLK);
        wr_req = 1'b0; rd_req = 2'b01; #1;
        check("coll_retry_gnt", rd_gnt, 2'b01);
        @(negedge CLK); idle(); #1;
        check("coll_id1", rd_id, 1'b1);
        check("coll_data1", rd_data, D3);
        @(negedge CLK); #1;
        check("coll_vld0", rd_vld, 1'b1);
        check("coll_id0", rd_id, 1'b0);
        check("coll_data0", rd_data, NEW1);

        // Write beats invalidate; invalidate alone clears.
        write(2'd1, X1);
        inval = 4'b0010;
        @(negedge CLK); idle(); inval = 4'b0010; #1;
        check("inval_wr_wins", entry_valid, 4'b1111);
        @(negedge CLK); idle();
        rd_req = 2'b10; rd_addr = {2'd1, 2'd0}; #1;
        check("inval_clear", entry_valid, 4'b1101);
        check("inval_miss", rd_miss, 2'b10);

        // In-flight read survives a following write and invalidate.
        @(negedge CLK); idle();
        rd_req = 2'b01; rd_addr = {2'd0, 2'd3}; #1;
        check("stale_gnt", rd_gnt, 2'b01);
        @(negedge CLK); idle();
        wr_req = 1'b1; wr_addr = 2'd3; wr_data = NEW3; inval = 4'b0001;
        @(negedge CLK); idle(); #1;
        check("stale_vld", rd_vld, 1'b1);
        check("stale_data", rd_data, D3);
        check("stale_valid", entry_valid, 4'b1100);

        // Reset with a read in flight.
        @(negedge CLK); idle();
        rd_req = 2'b01; rd_addr = {2'd0, 2'd2}; #1;
        check("mid_gnt", rd_gnt, 2'b01);
        @(negedge CLK);
        ARST_N = 1'b0; #1;
        check("mid_rst_gnt", rd_gnt, 2'b00);
        check("mid_rst_rdata_en", sram_r_data_en, 1'b0);
        check("mid_rst_valid", entry_valid, 4'b0000);
        check("mid_rst_blk_en", sram_blk_en, 1'b0);
        @(negedge CLK); idle();
        ARST_N = 1'b1;
        vld_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); #1;
            if (rd_vld) vld_seen++;
        end
        check("mid_no_vld", vld_seen, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
